// File: rtl/rca_pkg.sv
// ---------------------------------------------------------------------------
// rca_pkg
//   Shared constants for the registered ripple-carry adder.
//   RCA_WIDTH : default operand/sum width used by rca_4_bit_fa.
// ---------------------------------------------------------------------------
package rca_pkg;

  localparam int RCA_WIDTH = 4;

endpackage : rca_pkg

// File: rtl/rca_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//   One purely combinational ripple stage.
//   Ports:
//     a, b  : operand bits
//     cin   : carry from the previous stage (or the adder's Cin)
//     s     : sum bit
//     cout  : carry to the next stage
// ---------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;  // propagate term, shared by sum and carry

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/rca_4_bit_fa.sv
// ---------------------------------------------------------------------------
// rca_4_bit_fa
//   Ripple-carry adder built from WIDTH full_adder stages, followed by a
//   single output register stage. Inputs are sampled on every rising edge;
//   the result appears one cycle later.
//   Ports:
//     clk       : clock, all state updates on the rising edge
//     rst_n     : synchronous active-low reset
//     Sum       : registered sum bits
//     Cout      : registered carry-out of the MSB stage
//     A, B      : unsigned addends
//     Cin       : carry-in to stage 0
//     out_valid : high once a result from sampled inputs is held
//
//   Output qualifier: there is no input handshake and no ready. out_valid is
//   low after reset and rises on the first rising edge with rst_n high; from
//   then on every cycle presents a new Sum/Cout computed from the A/B/Cin
//   present at the previous rising edge.
// ---------------------------------------------------------------------------
module rca_4_bit_fa
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid
);

  // carry[i] is the carry into stage i; carry[WIDTH] is the final carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;

  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry[i]),
      .s    (sum_c[i]),
      .cout (carry[i+1])
    );
  end

  // Reset drops any in-flight result; the next non-reset edge loads fresh
  // inputs, so no separate flush is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Sum       <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      Sum       <= sum_c;
      Cout      <= carry[WIDTH];
      out_valid <= 1'b1;
    end
  end

endmodule : rca_4_bit_fa

// File: tb/tb_rca_4_bit_fa.sv
module tb_rca_4_bit_fa;

  localparam int WIDTH = 4;
  localparam int EW    = WIDTH + 2;  // {out_valid, Cout, Sum}

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];

  rca_4_bit_fa #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Sum       (sum),
    .Cout      (cout),
    .A         (a),
    .B         (b),
    .Cin       (cin),
    .out_valid (out_valid)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer addition, valid only outside reset.
  function automatic logic [EW-1:0] model(input int av, input int bv,
                                           input int cv, input logic rst);
    int total;
    if (!rst) return '0;
    total = av + bv + cv;
    return {1'b1, total[WIDTH:0]};
  endfunction

  // Driver: apply inputs at the falling edge, and after the rising edge
  // that samples them, queue the response the DUT must present next.
  task automatic drive(input int av, input int bv, input int cv,
                       input logic rst, input string name);
    @(negedge clk);
    a     = WIDTH'(av);
    b     = WIDTH'(bv);
    cin   = cv[0];
    rst_n = rst;
    @(posedge clk);
    #1;
    exp_q.push_back(model(av, bv, cv, rst));
    name_q.push_back(name);
  endtask

  // Monitor / scoreboard: outputs are registered, so each falling edge shows
  // the response to the most recently sampled inputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      string         n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if ({out_valid, cout, sum} !== e) begin
        failures++;
        $display("FAIL %s: got valid=%b cout=%b sum=%0d, expected valid=%b cout=%b sum=%0d",
                 n, out_valid, cout, sum, e[EW-1], e[WIDTH], e[WIDTH-1:0]);
      end
    end
  end

  initial begin
    int wait_cycles;
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;

    // Reset with nonzero inputs, then first result after release.
    drive(9, 9, 1, 1'b0, "reset_c1");
    drive(9, 9, 1, 1'b0, "reset_c2");
    drive(9, 9, 1, 1'b1, "first_after_reset");

    // Directed corner cases.
    drive(0, 0, 0, 1'b1, "zero");
    drive(5, 3, 1, 1'b1, "simple_5_3_1");
    drive(15, 0, 1, 1'b1, "ripple_15_0_1");
    drive(7, 8, 1, 1'b1, "ripple_7_8_1");
    drive(15, 15, 1, 1'b1, "max_15_15_1");
    drive(15, 15, 0, 1'b1, "max_15_15_0");

    // Exhaustive back-to-back sweep with one reset cycle injected mid-stream.
    for (int i = 0; i < 512; i++) begin
      if (i == 200) begin
        drive(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 1)), 1'b0, "midstream_reset");
      end
      drive((i >> 5) & 15, (i >> 1) & 15, i & 1, 1'b1, "sweep");
    end

    // Random back-to-back traffic.
    for (int i = 0; i < 64; i++) begin
      drive(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 1)), 1'b1, "random");
    end

    // Drain the scoreboard with a bounded wait.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rca_4_bit_fa
